dec_n_seq: RTL
==============

Name: dec_n_seq

Overview:
- Parametrised N-to-2^N one-hot decoder with registered outputs; the next generation of the team's 2-to-4 decoder.
- Adds two sequenced modes alongside plain enabled decode:
  - SCAN walks the one-hot output across all lines.
  - PULSE drives one selected line for a fixed number of cycles with a start/busy/done handshake.
- Sits in front of line-select/strobe logic (display digit scan, chip-select sequencing).

Parameters:
N, 2, address width; output width M = 2**N (N >= 1)
STEP, 4, cycles each SCAN position is held (>= 1)
PULSE_LEN, 3, cycles the PULSE line is asserted (>= 1)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
a  in  N  line address (DECODE, PULSE capture)
e  in  1  enable; low gates output (per mode rules below)
mode  in  2  00 DECODE, 01 SCAN, 10 PULSE, 11 OFF
start  in  1  PULSE request, sampled only in PULSE mode when idle
y  out  M  registered one-hot output, or all-zero
idx  out  N  index of the active line (valid when valid=1)
valid  out  1  y is non-zero this cycle
busy  out  1  PULSE in progress
done  out  1  one-cycle strobe: PULSE finished or SCAN wrapped M-1->0

Behaviour:
- Reset (async, immediate): y=0, idx=0, valid=0, busy=0, done=0, step/pulse counters=0, FSM=IDLE. Reset mid-pulse or mid-scan aborts silently; no done strobe.
- FSM states IDLE, DEC, SCAN, PULSE. While not busy, the next state follows mode each cycle: 00->DEC, 01->SCAN, 10->IDLE (PULSE armed), 11->IDLE.
- Invariant: y is always zero or exactly one-hot; y == (valid ? 1<<idx : 0).
- DEC:
  - Latency 1 cycle: y <= e ? 1<<a : 0; idx <= a; valid <= e.
  - done is never asserted in DEC.
- SCAN:
  - Entry from any other state: idx=0, step counter=0, y=1<<0 (if e=1) on the first SCAN cycle.
  - Each cycle with e=1 the step counter increments. When it reaches STEP-1 it clears, idx advances by 1, and y follows on the same edge.
  - Wrap: idx M-1 -> 0, with done=1 for that one cycle.
  - e=0: counter and idx frozen, y=0, valid=0. Resuming with e=1 continues from the frozen position; no re-entry reset.
  - STEP=1: advance every cycle.
- PULSE:
  - IDLE with mode=10, e=1, start=1: capture a. Next cycle: y=1<<a_cap, valid=1, busy=1, pulse counter=0.
  - y is held for exactly PULSE_LEN cycles, then y=0, valid=0, busy=0, done=1 for one cycle. Return to IDLE.
  - start while busy is ignored. a, e and mode changes while busy are ignored until done.
  - start asserted on the done cycle with mode=10 is accepted. The new pulse begins the following cycle, giving 1 dead cycle minimum between pulses.
  - start with e=0 or mode!=10 is ignored.
- OFF (11): y=0, valid=0, done=0.
- Mode change out of SCAN: takes effect the next cycle; no done strobe.
- Simultaneous SCAN wrap and mode change on the same edge: the wrap done is still issued.

Decomposition:
- Shared package dec_pkg:
  - mode encodings MODE_DEC, MODE_SCAN, MODE_PULSE, MODE_OFF
  - FSM state typedef/localparams
  - onehot(idx) function, reused by other decoders
- One natural sub-module: dec_step_cnt, a parametrised terminal-count counter with enable, clear and tc output. Instantiated twice, for the SCAN step counter and the PULSE length counter.

Test Plan (N=2, STEP=4, PULSE_LEN=3):
- DECODE sweep: mode=00, e=1, a=00,01,10,11 each for 10 ns -> y=0001,0010,0100,1000 one cycle after each change; e=0 -> y=0000, valid=0 next cycle.
- SCAN wrap: mode=01, e=1, 20 cycles:
  - y holds 0001 for 4 cycles, then 0010, 0100, 1000.
  - done=1 on exactly the cycle y returns to 0001, and not before.
  - Within the same 20-cycle run, drop e for 3 cycles mid-scan while y=0100 -> y=0000, then resume at 0100 with the remaining count preserved.
- PULSE handshake: mode=10, e=1, a=10, start=1 for 1 cycle:
  - Next cycle y=0100 and busy=1 for exactly 3 cycles, then y=0000 and done=1 for 1 cycle.
  - A second start and an a=01 change during busy have no effect.
- Back-to-back PULSE: start held high continuously -> pulses of 3 cycles separated by exactly 1 idle/done cycle; a sampled fresh at each acceptance.
- Reset mid-operation: assert rst asynchronously (off clock edge) during the 2nd pulse cycle and during SCAN idx=3 -> all outputs 0 immediately, no done. After release with mode=01, the scan restarts at 0001.
- Mode/OFF switching: SCAN at idx=2 -> mode=11 gives y=0000; mode=00 with a=11 gives y=1000 one cycle later; mode=11 with start=1 gives busy stays 0.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared definitions for the decoder family: mode encodings, sequencer states
// and a one-hot helper usable by any decoder up to 64 output lines.
package dec_pkg;

    typedef enum logic [1:0] {
        MODE_DEC   = 2'b00,
        MODE_SCAN  = 2'b01,
        MODE_PULSE = 2'b10,
        MODE_OFF   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DEC   = 2'b01,
        ST_SCAN  = 2'b10,
        ST_PULSE = 2'b11
    } state_e;

    localparam int unsigned ONEHOT_W = 64;

    // Callers truncate the result to their own line count.
    function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
        logic [ONEHOT_W-1:0] one_s;
        one_s = {{(ONEHOT_W-1){1'b0}}, 1'b1};
        return one_s << idx;
    endfunction

endpackage

// File: rtl/dec_step_cnt.sv
// Terminal-count counter: counts 0..LEN-1 while enabled, wraps to 0 after the
// terminal value; clr has priority and forces the count back to 0.
module dec_step_cnt #(
    parameter  int unsigned LEN = 4,
    localparam int unsigned W   = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'(LEN - 1);

    logic [W-1:0] cnt_r;

    assign tc = (cnt_r == LAST);

    // Count register with clear and wrap at the terminal value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (en) begin
            cnt_r <= tc ? {W{1'b0}} : cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/dec_n_seq.sv
// N-to-2^N one-hot decoder with registered outputs, plus SCAN (walking line)
// and PULSE (timed single-line strobe with start/busy/done) sequenced modes.
module dec_n_seq
    import dec_pkg::*;
#(
    parameter  int unsigned N         = 2,
    parameter  int unsigned STEP      = 4,
    parameter  int unsigned PULSE_LEN = 3,
    localparam int unsigned M         = 2 ** N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic         e,
    input  logic [1:0]   mode,
    input  logic         start,
    output logic [M-1:0] y,
    output logic [N-1:0] idx,
    output logic         valid,
    output logic         busy,
    output logic         done
);

    state_e       state_r, state_next_s;
    mode_e        mode_s;
    logic         step_tc_s, pulse_tc_s;
    logic         scan_entry_s, scan_run_s, pulse_accept_s, pulse_run_s, wrap_s;
    logic [M-1:0] y_r, y_d_s;
    logic [N-1:0] idx_r, idx_d_s;
    logic         valid_r, valid_d_s, busy_r, busy_d_s, done_r, done_d_s;

    assign mode_s         = mode_e'(mode);
    assign scan_entry_s   = (state_next_s == ST_SCAN) && (state_r != ST_SCAN);
    assign scan_run_s     = (state_next_s == ST_SCAN) && (state_r == ST_SCAN) && e;
    assign pulse_accept_s = (state_r == ST_IDLE) && (state_next_s == ST_PULSE);
    assign pulse_run_s    = (state_r == ST_PULSE);
    // A wrap due on this edge still strobes done even if the mode is changing.
    assign wrap_s         = (state_r == ST_SCAN) && e && step_tc_s && (&idx_r);

    dec_step_cnt #(.LEN(STEP)) u_step_cnt (
        .clk (clk),
        .rst (rst),
        .clr (scan_entry_s),
        .en  (scan_run_s),
        .tc  (step_tc_s)
    );

    dec_step_cnt #(.LEN(PULSE_LEN)) u_pulse_cnt (
        .clk (clk),
        .rst (rst),
        .clr (pulse_accept_s),
        .en  (pulse_run_s),
        .tc  (pulse_tc_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: a running pulse owns the FSM, otherwise follow mode
    always_comb begin
        state_next_s = state_r;
        if (state_r == ST_PULSE) begin
            if (pulse_tc_s) begin
                state_next_s = ST_IDLE;
            end else begin
                state_next_s = ST_PULSE;
            end
        end else begin
            case (mode_s)
                MODE_DEC:  state_next_s = ST_DEC;
                MODE_SCAN: state_next_s = ST_SCAN;
                MODE_PULSE: begin
                    if ((state_r == ST_IDLE) && e && start) begin
                        state_next_s = ST_PULSE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                MODE_OFF:  state_next_s = ST_IDLE;
                default:   state_next_s = ST_IDLE;
            endcase
        end
    end

    // Next output values; y is always derived from idx so it stays one-hot
    always_comb begin
        idx_d_s   = idx_r;
        valid_d_s = 1'b0;
        busy_d_s  = 1'b0;
        done_d_s  = wrap_s;
        case (state_next_s)
            ST_DEC: begin
                idx_d_s   = a;
                valid_d_s = e;
            end
            ST_SCAN: begin
                if (scan_entry_s) begin
                    idx_d_s   = {N{1'b0}};
                    valid_d_s = e;
                end else if (e) begin
                    idx_d_s   = step_tc_s ? idx_r + N'(1) : idx_r;
                    valid_d_s = 1'b1;
                end else begin
                    idx_d_s   = idx_r;
                    valid_d_s = 1'b0;
                end
            end
            ST_PULSE: begin
                if (pulse_accept_s) begin
                    idx_d_s = a;
                end else begin
                    idx_d_s = idx_r;
                end
                valid_d_s = 1'b1;
                busy_d_s  = 1'b1;
            end
            ST_IDLE: begin
                if (state_r == ST_PULSE) begin
                    done_d_s = 1'b1;
                end else begin
                    done_d_s = wrap_s;
                end
            end
            default: begin
                idx_d_s = idx_r;
            end
        endcase
        if (valid_d_s) begin
            y_d_s = M'(onehot(32'(idx_d_s)));
        end else begin
            y_d_s = {M{1'b0}};
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_r     <= {M{1'b0}};
            idx_r   <= {N{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            y_r     <= y_d_s;
            idx_r   <= idx_d_s;
            valid_r <= valid_d_s;
            busy_r  <= busy_d_s;
            done_r  <= done_d_s;
        end
    end

    assign y     = y_r;
    assign idx   = idx_r;
    assign valid = valid_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule
